// File: rtl/pipelined_cla_adder.sv
// Pipelined multi-segment carry-lookahead adder/subtractor.
// Ports: clk, rst, in_valid/in_ready, A, B, cin, sub, out_valid/out_ready, sum, cout, ovf.
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / 4;

  // Returns {carry into segment MSB, carry out, segment sum}.
  function automatic logic [SEG+1:0] cla_seg(
    input logic [SEG-1:0] a,
    input logic [SEG-1:0] b,
    input logic           ci
  );
    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG-1:0] s;
    logic [SEG:0]   c;
    logic [NGRP:0]  gc;
    logic [3:0]     pj;
    logic [3:0]     gj;
    logic           grp_p;
    logic           grp_g;
    p     = a ^ b;
    g     = a & b;
    c     = '0;
    gc    = '0;
    gc[0] = ci;
    for (int j = 0; j < NGRP; j++) begin
      pj    = p[4*j +: 4];
      gj    = g[4*j +: 4];
      grp_p = &pj;
      grp_g = gj[3]
            | (pj[3] & gj[2])
            | (pj[3] & pj[2] & gj[1])
            | (pj[3] & pj[2] & pj[1] & gj[0]);
      // Block lookahead: group carry from group P/G.
      gc[j+1]    = grp_g | (grp_p & gc[j]);
      c[4*j]     = gc[j];
      c[4*j + 1] = gj[0] | (pj[0] & gc[j]);
      c[4*j + 2] = gj[1] | (pj[1] & gj[0])
                 | (pj[1] & pj[0] & gc[j]);
      c[4*j + 3] = gj[2] | (pj[2] & gj[1])
                 | (pj[2] & pj[1] & gj[0])
                 | (pj[2] & pj[1] & pj[0] & gc[j]);
    end
    c[SEG] = gc[NGRP];
    s      = p ^ c[SEG-1:0];
    return {c[SEG-1], c[SEG], s};
  endfunction

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [SEG+1:0]    res [STAGES];

  logic             ov_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             stall;

  assign stall     = ov_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = ov_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Stage k resolves segment k; s_d[k] is its partial sum
  // with segments 0..k complete.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      res[k] = cla_seg(a_q[k][k*SEG +: SEG],
                       b_q[k][k*SEG +: SEG],
                       c_q[k]);
      s_d[k] = s_q[k];
      s_d[k][k*SEG +: SEG] = res[k][SEG-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      c_q    <= '0;
      ov_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (!stall) begin
      v_q[0] <= in_valid;
      a_q[0] <= A;
      b_q[0] <= sub ? ~B : B;
      c_q[0] <= sub | cin;
      s_q[0] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        s_q[k] <= s_d[k-1];
        c_q[k] <= res[k-1][SEG];
      end
      ov_q   <= v_q[STAGES-1];
      sum_q  <= s_d[STAGES-1];
      cout_q <= res[STAGES-1][SEG];
      ovf_q  <= res[STAGES-1][SEG+1]
              ^ res[STAGES-1][SEG];
    end
  end

endmodule
